// File: rtl/sonic_eth_loopback_line_skid_timing_adapter_pkg.sv
// Shared constants for the loopback line skid timing adapter.
// Covers payload width, default FIFO sizing and the drop-counter width.
package sonic_eth_loopback_line_skid_timing_adapter_pkg;
  localparam int LINE_W         = 72;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int AFULL_DEF      = 6;
  localparam int DROP_CNT_W     = 16;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;
  localparam drop_cnt_t DROP_CNT_MAX = '1;

  function automatic drop_cnt_t drop_cnt_inc(input drop_cnt_t v);
    return (v == DROP_CNT_MAX) ? v : v + drop_cnt_t'(1);
  endfunction
endpackage

// File: rtl/sonic_eth_loopback_line_skid_timing_adapter_if.sv
// Avalon-ST upstream/downstream bus and statistics signals of the skid adapter.
// The slave modport is the adapter's view; master is the driver/sink view.
interface sonic_eth_loopback_line_skid_timing_adapter_if
  import sonic_eth_loopback_line_skid_timing_adapter_pkg::*;
#(
  parameter int DATA_W = LINE_W,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) ();
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [FILL_W-1:0] fill_level;
  logic              overflow;
  drop_cnt_t         drop_count;
  logic              clear_stats;

  modport master (
    output in_data, in_valid, out_ready, clear_stats,
    input  in_ready, out_data, out_valid, fill_level, overflow, drop_count
  );

  modport slave (
    input  in_data, in_valid, out_ready, clear_stats,
    output in_ready, out_data, out_valid, fill_level, overflow, drop_count
  );
endinterface

// File: rtl/sonic_eth_loopback_line_fwft_fifo.sv
// First-word-fall-through circular FIFO; occupancy is tracked by a fill counter,
// so full/empty never depend on pointer comparison.
module sonic_eth_loopback_line_fwft_fifo #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int FILL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              accept,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [FILL_W-1:0] fill,
  output logic [FILL_W-1:0] fill_next
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, pop;

  assign full     = (fill == FILL_W'(DEPTH));
  assign rd_valid = (fill != '0);
  assign pop      = rd_valid & rd_ready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign accept   = wr_valid & (~full | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_comb begin
    fill_next = fill;
    case ({accept, pop})
      2'b10:   fill_next = fill + FILL_W'(1);
      2'b01:   fill_next = fill - FILL_W'(1);
      default: fill_next = fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      fill <= fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/sonic_eth_loopback_line_skid_timing_adapter.sv
// Timing adapter from a non-stallable source to a backpressuring sink:
// FWFT buffering, advisory almost-full, sticky overflow and saturating drop count.
module sonic_eth_loopback_line_skid_timing_adapter
  import sonic_eth_loopback_line_skid_timing_adapter_pkg::*;
#(
  parameter int DATA_W       = LINE_W,
  parameter int DEPTH        = FIFO_DEPTH_DEF,
  parameter int AFULL_THRESH = AFULL_DEF
) (
  input logic clk,
  input logic reset,
  sonic_eth_loopback_line_skid_timing_adapter_if.slave bus
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic              accept, drop;
  logic [FILL_W-1:0] fill, fill_next;
  logic              in_ready_q, overflow_q;
  drop_cnt_t         drop_count_q;

  sonic_eth_loopback_line_fwft_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (bus.in_valid),
    .wr_data   (bus.in_data),
    .rd_ready  (bus.out_ready),
    .accept    (accept),
    .rd_valid  (bus.out_valid),
    .rd_data   (bus.out_data),
    .fill      (fill),
    .fill_next (fill_next)
  );

  assign drop = bus.in_valid & ~accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q   <= 1'b1;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      in_ready_q <= (fill_next < FILL_W'(AFULL_THRESH));
      // A drop coincident with a clear is the first event of the new window.
      if (bus.clear_stats) begin
        overflow_q   <= drop;
        drop_count_q <= drop_cnt_t'(drop);
      end else if (drop) begin
        overflow_q   <= 1'b1;
        drop_count_q <= drop_cnt_inc(drop_count_q);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && drop) $display("%m: dropped beat %h at fill %0d", bus.in_data, fill);
  end
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
  assign bus.fill_level = fill;
endmodule

// File: tb/tb_sonic_eth_loopback_line_skid_timing_adapter.sv
// Directed bench for the skid timing adapter: streaming, backpressure, overflow,
// wrap-around reuse, counter saturation, clear_stats and mid-traffic reset.
module tb_sonic_eth_loopback_line_skid_timing_adapter;
  import sonic_eth_loopback_line_skid_timing_adapter_pkg::*;

  localparam int DATA_W = 72;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sonic_eth_loopback_line_skid_timing_adapter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sonic_eth_loopback_line_skid_timing_adapter #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid    = 1'b0;
    bus.clear_stats = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [71:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    bus.clear_stats = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_fill", bus.fill_level, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_drop_count", bus.drop_count, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Streaming with out_ready high: each beat shows one cycle later.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 72'(i);
      tick();
      check($sformatf("stream_valid_%0d", i), bus.out_valid, 1);
      check($sformatf("stream_data_%0d", i), bus.out_data, 72'(i));
      check($sformatf("stream_fill_le1_%0d", i), bus.fill_level <= 1, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_drained", bus.out_valid, 0);
    check("stream_overflow", bus.overflow, 0);

    // Backpressure: six pushes reach the almost-full threshold.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(72'(100 + i));
      check($sformatf("bp_fill_%0d", i), bus.fill_level, 72'(i + 1));
      check($sformatf("bp_in_ready_%0d", i), bus.in_ready, (i + 1 < AFULL) ? 1 : 0);
      check($sformatf("bp_head_%0d", i), bus.out_data, 100);
    end
    tick();
    check("bp_head_hold", bus.out_data, 100);
    check("bp_in_ready_hold", bus.in_ready, 0);

    // Overflow: eleven pushes into eight slots drop the last three.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      push(72'(200 + i));
      check($sformatf("ovf_fill_%0d", i), bus.fill_level, (i < 8) ? 72'(i + 1) : 72'(8));
      check($sformatf("ovf_drops_%0d", i), bus.drop_count, (i >= 8) ? 72'(i - 7) : 72'(0));
      check($sformatf("ovf_flag_%0d", i), bus.overflow, (i >= 8) ? 1 : 0);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain_valid_%0d", i), bus.out_valid, 1);
      check($sformatf("ovf_drain_data_%0d", i), bus.out_data, 72'(200 + i));
      tick();
    end
    check("ovf_drain_empty", bus.out_valid, 0);
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_count_final", bus.drop_count, 3);

    // Full with simultaneous pop: slot reused at wrapped write pointer.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(72'(300 + i));
    check("wrap_full", bus.fill_level, 8);
    bus.in_valid  = 1'b1;
    bus.in_data   = 72'(308);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("wrap_fill", bus.fill_level, 8);
    check("wrap_no_drop", bus.drop_count, 0);
    check("wrap_no_ovf", bus.overflow, 0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("wrap_data_%0d", i), bus.out_data, 72'(300 + i));
      tick();
    end
    check("wrap_empty", bus.out_valid, 0);

    // Saturation of the drop counter, then clear_stats with a coincident drop.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(72'(500 + i));
    bus.in_valid = 1'b1;
    bus.in_data  = 72'h0dead;
    repeat (65535) tick();
    check("sat_reach", bus.drop_count, 72'hffff);
    check("sat_ovf", bus.overflow, 1);
    tick();
    check("sat_hold", bus.drop_count, 72'hffff);
    bus.clear_stats = 1'b1;
    tick();
    check("clr_drop_count", bus.drop_count, 1);
    check("clr_overflow", bus.overflow, 1);
    bus.in_valid = 1'b0;
    tick();
    bus.clear_stats = 1'b0;
    check("clr_only_count", bus.drop_count, 0);
    check("clr_only_ovf", bus.overflow, 0);
    check("clr_fill_kept", bus.fill_level, 8);
    check("clr_head_kept", bus.out_data, 500);

    // Reset mid-traffic dominates a coincident push.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(72'(600 + i));
    check("mid_fill5", bus.fill_level, 5);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 72'(999);
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_fill", bus.fill_level, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    push(72'(700));
    check("fresh_valid", bus.out_valid, 1);
    check("fresh_data", bus.out_data, 700);
    check("fresh_fill", bus.fill_level, 1);
    tick();
    check("fresh_empty", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sonic_eth_loopback_line_skid_timing_adapter.md
Name: sonic_eth_loopback_line_skid_timing_adapter

Overview:
Avalon-ST timing adapter for the opposite case to the non-backpressurable line adapters. Its upstream source has no ready, and its downstream sink can deassert ready. A small first-word-fall-through FIFO absorbs downstream backpressure so that beats are not lost silently. Overflow is flagged and counted. It sits between the 10G loopback line splitter output and any sink that applies backpressure.

Parameters:
DATA_W, 72, payload width (64 data + 8 control).
DEPTH, 8, FIFO entries; power of two, at least 2.
AFULL_THRESH, 6, fill level at or above which the advisory in_ready deasserts; must be at most DEPTH.

Ports:
clk  in  1  single clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
in_data  in  DATA_W  upstream payload.
in_valid  in  1  upstream beat strobe; upstream cannot be stalled.
in_ready  out  1  advisory almost-full indication; upstream may ignore it.
out_data  out  DATA_W  downstream payload.
out_valid  out  1  downstream beat available.
out_ready  in  1  downstream accept; ready latency 0.
fill_level  out  clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky; set when a beat is dropped.
drop_count  out  16  saturating count of dropped beats.
clear_stats  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs):
  - wr_ptr, rd_ptr and fill_level go to 0.
  - out_valid=0, out_data=0, overflow=0, drop_count=0, in_ready=1.
  - In-flight FIFO contents are discarded.
- Storage:
  - Circular register array of DEPTH entries.
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Empty/full are determined from fill_level, not from pointer compare.
- push = in_valid and (not full, or pop in the same cycle).
- pop = out_valid and out_ready.
- Latency: a beat pushed in cycle N appears on out_data with out_valid=1 in cycle N+1 at the earliest. There is no combinational in-to-out path.
- Output (FWFT):
  - out_valid = (fill_level != 0).
  - out_data = mem[rd_ptr] while out_valid=1; forced to 0 while out_valid=0.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Fill level updates:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full with a simultaneous pop: the slot is reused, the beat is accepted, no drop.
- Full with no pop and in_valid=1:
  - The beat is dropped; the FIFO is not modified.
  - overflow is set the next cycle.
  - drop_count increments and saturates at 16'hFFFF.
- Empty with in_valid=1: the beat is written and out_valid rises the next cycle (no bypass).
- in_ready = (fill_level < AFULL_THRESH), registered from the next-state fill level so it is glitch-free.
- clear_stats:
  - Clears overflow and drop_count next cycle.
  - If a drop occurs in the same cycle, the result is overflow=1 and drop_count=1.
  - FIFO contents are unaffected.
- Simulation-only check: $display on every dropped beat, excluded from synthesis.

Decomposition:
- Shared package holds:
  - Avalon-ST line payload width constant (72).
  - Default FIFO depth.
  - drop counter width (16) and its saturation constant.
- One natural sub-module: sonic_eth_loopback_line_fwft_fifo (storage array, pointers, fill level).
- Statistics and in_ready logic stay in the top module.

Test Plan:
- Reset, then out_ready=1 and 20 consecutive in_valid beats with data 0..19 -> out emits 0..19 in order, each one cycle after input; fill_level never exceeds 1; overflow=0.
- out_ready=0, push 6 beats -> fill_level=6, in_ready=0 from the cycle after the 6th push; out_data holds beat 0 stable.
- out_ready=0, push 11 beats into DEPTH=8 -> beats 8..10 dropped; overflow=1; drop_count=3; releasing out_ready outputs exactly beats 0..7.
- Fill to 8, then in_valid=1 and out_ready=1 in the same cycle -> no drop; fill_level stays 8; beat accepted at the wrapped write pointer.
- Preload drop_count=16'hFFFF and force one more drop -> stays 16'hFFFF; clear_stats with a coincident drop -> drop_count=1, overflow=1.
- Assert reset with fill_level=5 -> next cycle out_valid=0, fill_level=0, out_data=0; subsequent traffic starts fresh at beat 0.
